// File: rtl/store_flush_sequencer.sv
// Purpose: drains the four 64-bit rows of the core store-register bank into data memory when all cores raise MEMWR.
// Latency: trigger at edge T -> SELECT/ISSUE pairs in cycles T+1..T+8, DONE in T+9 (MEM_READY high).
// Backpressure: MEM_WE/MEM_ADDR/MEM_WDATA hold while MEM_READY is low; abort with sticky ERROR after TIMEOUT stalls.
module store_flush_sequencer #(
    parameter int          NUM_ROWS   = 4,
    parameter logic [3:0]  ROW_BASE   = 4'b1000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 64,
    parameter int          TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  MEMWR_1,
    input  logic                  MEMWR_2,
    input  logic                  MEMWR_3,
    input  logic                  MEMWR_4,
    input  logic [ADDR_WIDTH-1:0] MEM_BASE,
    input  logic [DATA_WIDTH-1:0] ROW_DATA,
    input  logic                  MEM_READY,
    output logic                  WRITE_MEM,
    output logic [3:0]            ROW_ADDR,
    output logic                  MEM_WE,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERROR
);

    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;

    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                state;
    logic [ROW_W-1:0]      row;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic                  all_wr_q;

    logic                  all_wr;
    logic                  trigger;
    logic                  xfer;
    logic [ROW_W-1:0]      row_nxt;

    // Trigger detection and handshake qualification; MEM_READY only counts while a write is offered.
    always_comb begin
        all_wr  = MEMWR_1 & MEMWR_2 & MEMWR_3 & MEMWR_4;
        trigger = all_wr & ~all_wr_q & (state == S_IDLE);
        xfer    = MEM_WE & MEM_READY;
        row_nxt = row + ROW_W'(1);
    end

    // Flush FSM with all outputs registered alongside the state so they change only at clock edges (or reset).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            row       <= '0;
            wait_cnt  <= '0;
            base_q    <= '0;
            all_wr_q  <= 1'b0;
            WRITE_MEM <= 1'b0;
            ROW_ADDR  <= 4'b0000;
            MEM_WE    <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            ERROR     <= 1'b0;
        end else begin
            // Tracked every cycle so a level held through a flush never looks like a new edge afterwards.
            all_wr_q <= all_wr;

            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        base_q    <= MEM_BASE;
                        row       <= '0;
                        ERROR     <= 1'b0;
                        WRITE_MEM <= 1'b1;
                        ROW_ADDR  <= ROW_BASE;
                        BUSY      <= 1'b1;
                        state     <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    // Bank presents the selected row this cycle; capture it as the write payload.
                    MEM_WDATA <= ROW_DATA;
                    MEM_ADDR  <= base_q + ADDR_WIDTH'(row);
                    wait_cnt  <= '0;
                    WRITE_MEM <= 1'b0;
                    MEM_WE    <= 1'b1;
                    state     <= S_ISSUE;
                end

                S_ISSUE: begin
                    if (xfer) begin
                        // A ready on the final wait cycle still completes the row.
                        MEM_WE <= 1'b0;
                        if (row == LAST_ROW) begin
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            row       <= row_nxt;
                            WRITE_MEM <= 1'b1;
                            ROW_ADDR  <= ROW_BASE + 4'(row_nxt);
                            state     <= S_SELECT;
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        ERROR  <= 1'b1;
                        MEM_WE <= 1'b0;
                        BUSY   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                S_DONE: begin
                    DONE  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    WRITE_MEM <= 1'b0;
                    MEM_WE    <= 1'b0;
                    BUSY      <= 1'b0;
                    DONE      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_flush_sequencer.sv
module tb_store_flush_sequencer;

    logic        clk = 1'b0;
    logic        rstn;
    logic [3:0]  memwr;
    logic [7:0]  mem_base;
    logic [63:0] row_data;
    logic        mem_ready;
    logic        write_mem;
    logic [3:0]  row_addr;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [63:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] wr;
        logic       rdy;
        logic [7:0] base;
        logic       wm;
        logic [3:0] ra;
        logic       we;
        logic [7:0] addr;
        logic       busy;
        logic       done;
        logic       err;
        int         row;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    store_flush_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .MEMWR_1   (memwr[0]),
        .MEMWR_2   (memwr[1]),
        .MEMWR_3   (memwr[2]),
        .MEMWR_4   (memwr[3]),
        .MEM_BASE  (mem_base),
        .ROW_DATA  (row_data),
        .MEM_READY (mem_ready),
        .WRITE_MEM (write_mem),
        .ROW_ADDR  (row_addr),
        .MEM_WE    (mem_we),
        .MEM_ADDR  (mem_addr),
        .MEM_WDATA (mem_wdata),
        .BUSY      (busy),
        .DONE      (done),
        .ERROR     (error)
    );

    // Register bank contents: row k holds four consecutive 16-bit words starting at 4k+1.
    function automatic logic [63:0] bank_row(input int k);
        return {16'(4*k+1), 16'(4*k+2), 16'(4*k+3), 16'(4*k+4)};
    endfunction

    // Bank only drives a real row while selected; garbage otherwise so a mistimed capture shows up.
    assign row_data = write_mem ? bank_row(int'(row_addr) - 8) : 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic wm, input logic [3:0] ra, input logic we,
                            input logic [7:0] addr, input logic bsy, input logic dn, input logic err,
                            input int row);
        chk({tag, ".write_mem"}, 64'(write_mem), 64'(wm));
        chk({tag, ".row_addr"},  64'(row_addr),  64'(ra));
        chk({tag, ".mem_we"},    64'(mem_we),    64'(we));
        chk({tag, ".mem_addr"},  64'(mem_addr),  64'(addr));
        chk({tag, ".busy"},      64'(busy),      64'(bsy));
        chk({tag, ".done"},      64'(done),      64'(dn));
        chk({tag, ".error"},     64'(error),     64'(err));
        if (row >= 0) chk({tag, ".wdata"}, mem_wdata, bank_row(row));
    endtask

    // Advance to the next falling edge, then drive the inputs sampled at the following rising edge.
    task automatic cyc(input logic [3:0] wr, input logic rdy, input logic [7:0] base);
        @(negedge clk);
        memwr     = wr;
        mem_ready = rdy;
        mem_base  = base;
    endtask

    task automatic add(input logic [3:0] wr, input logic rdy, input logic [7:0] base,
                       input logic wm, input logic [3:0] ra, input logic we, input logic [7:0] addr,
                       input logic bsy, input logic dn, input logic err, input int row);
        vec_t v;
        v.wr = wr; v.rdy = rdy; v.base = base;
        v.wm = wm; v.ra = ra; v.we = we; v.addr = addr;
        v.busy = bsy; v.done = dn; v.err = err; v.row = row;
        tbl.push_back(v);
    endtask

    initial begin
        // Basic flush, base 0x10; MEM_BASE changes after the trigger and must be ignored.
        add(4'h0, 1, 8'h10, 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        add(4'hF, 1, 8'h10, 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);   // T
        add(4'hF, 1, 8'h77, 1, 4'h8, 0, 8'h00, 1, 0, 0, -1);   // T+1 select row 0
        add(4'hF, 1, 8'h77, 0, 4'h8, 1, 8'h10, 1, 0, 0,  0);
        add(4'hF, 1, 8'h77, 1, 4'h9, 0, 8'h10, 1, 0, 0, -1);
        add(4'hF, 1, 8'h77, 0, 4'h9, 1, 8'h11, 1, 0, 0,  1);
        add(4'hF, 1, 8'h77, 1, 4'hA, 0, 8'h11, 1, 0, 0, -1);
        add(4'hF, 1, 8'h77, 0, 4'hA, 1, 8'h12, 1, 0, 0,  2);
        add(4'hF, 1, 8'h77, 1, 4'hB, 0, 8'h12, 1, 0, 0, -1);
        add(4'hF, 1, 8'h77, 0, 4'hB, 1, 8'h13, 1, 0, 0,  3);
        add(4'hF, 1, 8'h77, 0, 4'hB, 0, 8'h13, 0, 1, 0, -1);   // T+9 done
        // Level held: no retrigger.
        for (int i = 0; i < 3; i++) add(4'hF, 1, 8'h77, 0, 4'hB, 0, 8'h13, 0, 0, 0, -1);
        add(4'h0, 1, 8'h77, 0, 4'hB, 0, 8'h13, 0, 0, 0, -1);
        // Retrigger with wrapping base 0xFE.
        add(4'hF, 1, 8'hFE, 0, 4'hB, 0, 8'h13, 0, 0, 0, -1);   // T
        add(4'hF, 1, 8'h55, 1, 4'h8, 0, 8'h13, 1, 0, 0, -1);
        add(4'hF, 1, 8'h55, 0, 4'h8, 1, 8'hFE, 1, 0, 0,  0);
        add(4'hF, 1, 8'h55, 1, 4'h9, 0, 8'hFE, 1, 0, 0, -1);
        add(4'hF, 1, 8'h55, 0, 4'h9, 1, 8'hFF, 1, 0, 0,  1);
        add(4'hF, 1, 8'h55, 1, 4'hA, 0, 8'hFF, 1, 0, 0, -1);
        add(4'hF, 1, 8'h55, 0, 4'hA, 1, 8'h00, 1, 0, 0,  2);
        add(4'hF, 1, 8'h55, 1, 4'hB, 0, 8'h00, 1, 0, 0, -1);
        add(4'hF, 1, 8'h55, 0, 4'hB, 1, 8'h01, 1, 0, 0,  3);
        add(4'hF, 1, 8'h55, 0, 4'hB, 0, 8'h01, 0, 1, 0, -1);
        // Partial strobes for 10 cycles: nothing happens.
        for (int i = 0; i < 10; i++) add(4'h7, 1, 8'h20, 0, 4'hB, 0, 8'h01, 0, 0, 0, -1);
        // MEMWR_4 rises: flush with 3 stall cycles on row 1, DONE at T+12.
        add(4'hF, 1, 8'h20, 0, 4'hB, 0, 8'h01, 0, 0, 0, -1);   // T
        add(4'hF, 1, 8'h33, 1, 4'h8, 0, 8'h01, 1, 0, 0, -1);
        add(4'hF, 1, 8'h33, 0, 4'h8, 1, 8'h20, 1, 0, 0,  0);
        add(4'hF, 1, 8'h33, 1, 4'h9, 0, 8'h20, 1, 0, 0, -1);
        add(4'hF, 0, 8'h33, 0, 4'h9, 1, 8'h21, 1, 0, 0,  1);
        add(4'hF, 0, 8'h33, 0, 4'h9, 1, 8'h21, 1, 0, 0,  1);
        add(4'hF, 0, 8'h33, 0, 4'h9, 1, 8'h21, 1, 0, 0,  1);
        add(4'hF, 1, 8'h33, 0, 4'h9, 1, 8'h21, 1, 0, 0,  1);
        add(4'hF, 1, 8'h33, 1, 4'hA, 0, 8'h21, 1, 0, 0, -1);
        add(4'hF, 1, 8'h33, 0, 4'hA, 1, 8'h22, 1, 0, 0,  2);
        add(4'hF, 1, 8'h33, 1, 4'hB, 0, 8'h22, 1, 0, 0, -1);
        add(4'hF, 1, 8'h33, 0, 4'hB, 1, 8'h23, 1, 0, 0,  3);
        add(4'hF, 1, 8'h33, 0, 4'hB, 0, 8'h23, 0, 1, 0, -1);   // T+12 done
        add(4'hF, 1, 8'h33, 0, 4'hB, 0, 8'h23, 0, 0, 0, -1);

        memwr = 4'h0; mem_ready = 1'b1; mem_base = 8'h00;
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1 chk_outs("reset", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        foreach (tbl[i]) begin
            cyc(tbl[i].wr, tbl[i].rdy, tbl[i].base);
            chk_outs($sformatf("v%0d", i), tbl[i].wm, tbl[i].ra, tbl[i].we, tbl[i].addr,
                     tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].row);
        end

        // Timeout: MEM_READY stuck low on row 0.
        cyc(4'h0, 0, 8'h40); chk_outs("to.idle", 0, 4'hB, 0, 8'h23, 0, 0, 0, -1);
        cyc(4'hF, 0, 8'h40); chk_outs("to.trig", 0, 4'hB, 0, 8'h23, 0, 0, 0, -1);
        cyc(4'hF, 0, 8'h40); chk_outs("to.sel",  1, 4'h8, 0, 8'h23, 1, 0, 0, -1);
        for (int i = 0; i < 16; i++) begin
            cyc(4'hF, 0, 8'h40);
            chk_outs($sformatf("to.iss%0d", i), 0, 4'h8, 1, 8'h40, 1, 0, 0, 0);
        end
        cyc(4'hF, 0, 8'h40); chk_outs("to.abort", 0, 4'h8, 0, 8'h40, 0, 0, 1, -1);
        for (int i = 0; i < 3; i++) begin
            cyc(4'hF, 1, 8'h40);
            chk_outs($sformatf("to.hold%0d", i), 0, 4'h8, 0, 8'h40, 0, 0, 1, -1);
        end
        // Fresh edge clears ERROR and restarts at row 0; reset lands in row 2 ISSUE.
        cyc(4'h0, 1, 8'h60); chk_outs("re.low",  0, 4'h8, 0, 8'h40, 0, 0, 1, -1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.trig", 0, 4'h8, 0, 8'h40, 0, 0, 1, -1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.sel0", 1, 4'h8, 0, 8'h40, 1, 0, 0, -1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.iss0", 0, 4'h8, 1, 8'h60, 1, 0, 0,  0);
        cyc(4'hF, 1, 8'h60); chk_outs("re.sel1", 1, 4'h9, 0, 8'h60, 1, 0, 0, -1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.iss1", 0, 4'h9, 1, 8'h61, 1, 0, 0,  1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.sel2", 1, 4'hA, 0, 8'h61, 1, 0, 0, -1);
        cyc(4'hF, 1, 8'h60); chk_outs("re.iss2", 0, 4'hA, 1, 8'h62, 1, 0, 0,  2);

        // Async reset between clock edges.
        #2 rstn = 1'b0;
        #1 chk_outs("ar.now", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        cyc(4'h0, 1, 8'h80); chk_outs("ar.hold0", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        cyc(4'h0, 1, 8'h80); chk_outs("ar.hold1", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        rstn = 1'b1;
        cyc(4'h0, 1, 8'h80); chk_outs("ar.idle", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        cyc(4'hF, 1, 8'h80); chk_outs("ar.trig", 0, 4'h0, 0, 8'h00, 0, 0, 0, -1);
        cyc(4'hF, 1, 8'h80); chk_outs("ar.sel0", 1, 4'h8, 0, 8'h00, 1, 0, 0, -1);
        cyc(4'hF, 1, 8'h80); chk_outs("ar.iss0", 0, 4'h8, 1, 8'h80, 1, 0, 0,  0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
